// File: rtl/sram_port0_arbiter.sv
// rtl/sram_port0_arbiter.sv - two-requester arbiter and response pipeline for SRAM RW port 0
//
// Ports:
//   clk0, rst          clock (also the SRAM clk0) and synchronous active-high reset
//   boot_mode          1 = only requester 0 may be granted
//   m0_* / m1_*        requester command (valid/ready/we/wmask/addr/wdata) and
//                      response (resp_valid pulse, rdata) interfaces
//   sram_csb0..din0    registered command to the SRAM macro port 0
//   sram_dout0         SRAM port 0 read data
//   busy               a command is in stage 1 or stage 2
module sram_port0_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4,
    parameter int ARB_MODE   = 1
) (
    input  logic                  clk0,
    input  logic                  rst,
    input  logic                  boot_mode,

    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic                  m0_we,
    input  logic [NUM_WMASKS-1:0] m0_wmask,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_resp_valid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic                  m1_we,
    input  logic [NUM_WMASKS-1:0] m1_wmask,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_resp_valid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,

    output logic                  busy
);

    localparam bit FIXED_PRIO = (ARB_MODE == 0);

    // last_grant: owner of the most recent accepted command (0 or 1)
    logic last_grant;

    // stage 1: command registered to the SRAM; stage 2: SRAM has sampled it
    logic s1_valid, s1_owner, s1_read;
    logic s2_valid, s2_owner, s2_read;

    logic                  accept;
    logic                  sel_owner;
    logic                  sel_we;
    logic [NUM_WMASKS-1:0] sel_wmask;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Requester 0 wins unless round-robin says it is requester 1's turn;
    // boot_mode forces requester 0 regardless of last_grant.
    always_comb begin
        m0_ready = m0_valid & (FIXED_PRIO | !m1_valid | last_grant | boot_mode);
        m1_ready = m1_valid & !boot_mode & !m0_ready;
    end

    always_comb begin
        accept    = m0_ready | m1_ready;
        sel_owner = m1_ready;
        if (m1_ready) begin
            sel_we    = m1_we;
            sel_wmask = m1_wmask;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end else begin
            sel_we    = m0_we;
            sel_wmask = m0_wmask;
            sel_addr  = m0_addr;
            sel_wdata = m0_wdata;
        end
    end

    always_ff @(posedge clk0) begin
        if (rst) begin
            sram_csb0     <= 1'b1;
            sram_web0     <= 1'b1;
            sram_wmask0   <= '0;
            sram_addr0    <= '0;
            sram_din0     <= '0;
            last_grant    <= 1'b1;
            s1_valid      <= 1'b0;
            s1_owner      <= 1'b0;
            s1_read       <= 1'b0;
            s2_valid      <= 1'b0;
            s2_owner      <= 1'b0;
            s2_read       <= 1'b0;
            m0_resp_valid <= 1'b0;
            m1_resp_valid <= 1'b0;
            m0_rdata      <= '0;
            m1_rdata      <= '0;
        end else begin
            if (accept) begin
                sram_csb0   <= 1'b0;
                sram_web0   <= !sel_we;
                sram_addr0  <= sel_addr;
                sram_din0   <= sel_wdata;
                // reads drive an all-zero mask so the macro never sees stray byte enables
                sram_wmask0 <= sel_we ? sel_wmask : '0;
                last_grant  <= sel_owner;
            end else begin
                // idle: deselect but hold address/data/mask to avoid needless toggling
                sram_csb0 <= 1'b1;
                sram_web0 <= 1'b1;
            end

            s1_valid <= accept;
            s1_owner <= sel_owner;
            s1_read  <= !sel_we;

            s2_valid <= s1_valid;
            s2_owner <= s1_owner;
            s2_read  <= s1_read;

            // sram_dout0 settled at the negedge after the sampling edge, so it is
            // stable here, one edge after the tag reached stage 2
            m0_resp_valid <= s2_valid & !s2_owner;
            m1_resp_valid <= s2_valid &  s2_owner;
            if (s2_valid && s2_read && !s2_owner) begin
                m0_rdata <= sram_dout0;
            end
            if (s2_valid && s2_read && s2_owner) begin
                m1_rdata <= sram_dout0;
            end
        end
    end

    assign busy = s1_valid | s2_valid;

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// tb/tb_sram_port0_arbiter.sv - directed self-checking bench for sram_port0_arbiter
module tb_sram_port0_arbiter;

    logic        clk0 = 1'b0;
    logic        rst;
    logic        boot_mode;
    logic        m0_valid, m0_ready, m0_we, m0_resp_valid;
    logic [3:0]  m0_wmask;
    logic [7:0]  m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_valid, m1_ready, m1_we, m1_resp_valid;
    logic [3:0]  m1_wmask;
    logic [7:0]  m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic        sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    // expected rdata per requester, updated by the bench on each read response
    logic [31:0] exp_rd0, exp_rd1;

    // per-cycle stimulus tables for arbitration runs (exp_g: 0, 1, or 2 = no grant)
    int tb_boot [16];
    int tb_v0   [16];
    int tb_v1   [16];
    int exp_g   [16];

    always #5 clk0 = ~clk0;

    sram_port0_arbiter #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(32),
        .NUM_WMASKS(4),
        .ARB_MODE(1)
    ) dut (
        .clk0(clk0), .rst(rst), .boot_mode(boot_mode),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_wmask(m0_wmask),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_resp_valid(m0_resp_valid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_wmask(m1_wmask),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_resp_valid(m1_resp_valid), .m1_rdata(m1_rdata),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
        .busy(busy)
    );

    // SRAM macro model: samples at posedge, writes or reads at the following negedge
    logic [31:0] mem [0:255];
    logic        csb_q, web_q;
    logic [3:0]  wmask_q;
    logic [7:0]  addr_q;
    logic [31:0] din_q;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        sram_dout0 = 32'h0;
        csb_q = 1'b1;
        web_q = 1'b1;
        wmask_q = 4'h0;
        addr_q = 8'h0;
        din_q = 32'h0;
    end

    always @(posedge clk0) begin
        csb_q   <= sram_csb0;
        web_q   <= sram_web0;
        wmask_q <= sram_wmask0;
        addr_q  <= sram_addr0;
        din_q   <= sram_din0;
    end

    always @(negedge clk0) begin
        if (!csb_q) begin
            if (!web_q) begin
                for (int b = 0; b < 4; b++) begin
                    if (wmask_q[b]) mem[addr_q][8*b +: 8] <= din_q[8*b +: 8];
                end
            end else begin
                sram_dout0 <= mem[addr_q];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk0);
        #1;
    endtask

    task automatic idle_inputs();
        m0_valid = 0; m0_we = 0; m0_wmask = 0; m0_addr = 0; m0_wdata = 0;
        m1_valid = 0; m1_we = 0; m1_wmask = 0; m1_addr = 0; m1_wdata = 0;
        boot_mode = 0;
    endtask

    task automatic drive(input bit r, input bit v, input bit we, input logic [3:0] wm,
                         input logic [7:0] a, input logic [31:0] wd);
        if (r) begin
            m1_valid = v; m1_we = we; m1_wmask = wm; m1_addr = a; m1_wdata = wd;
        end else begin
            m0_valid = v; m0_we = we; m0_wmask = wm; m0_addr = a; m0_wdata = wd;
        end
    endtask

    task automatic do_reset();
        rst = 1;
        next_cycle();
        next_cycle();
        rst = 0;
        exp_rd0 = 32'h0;
        exp_rd1 = 32'h0;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk0);
        chk({tag, "_csb"}, sram_csb0, 1);
        chk({tag, "_web"}, sram_web0, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rv0"}, m0_resp_valid, 0);
        chk({tag, "_rv1"}, m1_resp_valid, 0);
        chk({tag, "_rd0"}, m0_rdata, exp_rd0);
        chk({tag, "_rd1"}, m1_rdata, exp_rd1);
        next_cycle();
    endtask

    // One isolated command from requester r, checked cycle by cycle through its response
    task automatic single(input string tag, input bit r, input bit we, input logic [3:0] wm,
                          input logic [7:0] a, input logic [31:0] wd, input logic [31:0] rd);
        drive(r, 1, we, wm, a, wd);
        @(negedge clk0);
        chk({tag, "_ready"}, r ? m1_ready : m0_ready, 1);
        chk({tag, "_other_ready"}, r ? m0_ready : m1_ready, 0);
        next_cycle();
        drive(r, 0, 0, 0, 0, 0);
        @(negedge clk0);
        chk({tag, "_csb_e0"}, sram_csb0, 0);
        chk({tag, "_web_e0"}, sram_web0, !we);
        chk({tag, "_addr"}, sram_addr0, a);
        chk({tag, "_din"}, sram_din0, wd);
        chk({tag, "_wmask"}, sram_wmask0, we ? wm : 4'h0);
        chk({tag, "_busy_e0"}, busy, 1);
        next_cycle();
        @(negedge clk0);
        chk({tag, "_csb_e1"}, sram_csb0, 1);
        chk({tag, "_busy_e1"}, busy, 1);
        chk({tag, "_rv_e1"}, r ? m1_resp_valid : m0_resp_valid, 0);
        next_cycle();
        @(negedge clk0);
        if (!we) begin
            if (r) exp_rd1 = rd;
            else   exp_rd0 = rd;
        end
        chk({tag, "_rv"}, r ? m1_resp_valid : m0_resp_valid, 1);
        chk({tag, "_rv_other"}, r ? m0_resp_valid : m1_resp_valid, 0);
        chk({tag, "_rd0"}, m0_rdata, exp_rd0);
        chk({tag, "_rd1"}, m1_rdata, exp_rd1);
        chk({tag, "_busy_e2"}, busy, 0);
        next_cycle();
        @(negedge clk0);
        chk({tag, "_rv_end0"}, m0_resp_valid, 0);
        chk({tag, "_rv_end1"}, m1_resp_valid, 0);
        next_cycle();
    endtask

    // Both requesters read fixed addresses under the per-cycle tables; responses
    // are expected three table rows after the grant row.
    task automatic run_table(input string tag, input int n, input logic [7:0] a0, input logic [7:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1);
        for (int k = 0; k < n; k++) begin
            boot_mode = tb_boot[k][0];
            drive(0, tb_v0[k][0], 0, 4'h0, a0, 32'h0);
            drive(1, tb_v1[k][0], 0, 4'h0, a1, 32'h0);
            @(negedge clk0);
            chk($sformatf("%s_k%0d_ready0", tag, k), m0_ready, exp_g[k] == 0);
            chk($sformatf("%s_k%0d_ready1", tag, k), m1_ready, exp_g[k] == 1);
            if (k >= 3 && exp_g[k-3] == 0) exp_rd0 = d0;
            if (k >= 3 && exp_g[k-3] == 1) exp_rd1 = d1;
            chk($sformatf("%s_k%0d_rv0", tag, k), m0_resp_valid, k >= 3 && exp_g[k-3] == 0);
            chk($sformatf("%s_k%0d_rv1", tag, k), m1_resp_valid, k >= 3 && exp_g[k-3] == 1);
            chk($sformatf("%s_k%0d_rd0", tag, k), m0_rdata, exp_rd0);
            chk($sformatf("%s_k%0d_rd1", tag, k), m1_rdata, exp_rd1);
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1;
        exp_rd0 = 32'h0;
        exp_rd1 = 32'h0;
        next_cycle();
        @(negedge clk0);
        chk("rst_wmask", sram_wmask0, 0);
        chk("rst_addr", sram_addr0, 0);
        chk("rst_din", sram_din0, 0);
        do_reset();
        check_idle("rst");

        // 1: write then read back through requester 0
        single("t1_wr", 0, 1, 4'hF, 8'h05, 32'hDEADBEEF, 32'h0);
        single("t1_rd", 0, 0, 4'h0, 8'h05, 32'h0, 32'hDEADBEEF);

        // 2: byte-masked writes, and a zero-mask write that leaves memory alone
        single("t2_wr_full", 0, 1, 4'hF, 8'h10, 32'h11223344, 32'h0);
        single("t2_wr_mask", 0, 1, 4'h5, 8'h10, 32'hAABBCCDD, 32'h0);
        single("t2_rd", 0, 0, 4'h0, 8'h10, 32'h0, 32'h11BB33DD);
        single("t2_wr_zero", 0, 1, 4'h0, 8'h10, 32'hFFFFFFFF, 32'h0);
        single("t2_rd_zero", 0, 0, 4'h0, 8'h10, 32'h0, 32'h11BB33DD);

        // 3: round-robin from reset, both requesters valid for 6 cycles
        single("t3_pre0", 0, 1, 4'hF, 8'h01, 32'hA1A1A1A1, 32'h0);
        single("t3_pre1", 1, 1, 4'hF, 8'h02, 32'hB2B2B2B2, 32'h0);
        do_reset();
        for (int k = 0; k < 16; k++) begin
            tb_boot[k] = 0;
            tb_v0[k]   = (k < 6) ? 1 : 0;
            tb_v1[k]   = (k < 6) ? 1 : 0;
            exp_g[k]   = (k < 6) ? (k % 2) : 2;
        end
        run_table("t3", 10, 8'h01, 8'h02, 32'hA1A1A1A1, 32'hB2B2B2B2);

        // 4: m1 in flight when boot_mode rises, m0 locked in, m1 granted once released
        for (int k = 0; k < 16; k++) begin
            tb_boot[k] = (k >= 1 && k <= 4) ? 1 : 0;
            tb_v0[k]   = (k >= 1 && k <= 5) ? 1 : 0;
            tb_v1[k]   = (k <= 5) ? 1 : 0;
            exp_g[k]   = (k == 0 || k == 5) ? 1 : ((k <= 4) ? 0 : 2);
        end
        run_table("t4", 10, 8'h01, 8'h02, 32'hA1A1A1A1, 32'hB2B2B2B2);

        // 5: back-to-back write then read of the same address by requester 1
        drive(1, 1, 1, 4'hF, 8'h20, 32'h00000007);
        @(negedge clk0);
        chk("t5_wr_ready", m1_ready, 1);
        next_cycle();
        drive(1, 1, 0, 4'h0, 8'h20, 32'h0);
        @(negedge clk0);
        chk("t5_rd_ready", m1_ready, 1);
        chk("t5_web_wr", sram_web0, 0);
        next_cycle();
        drive(1, 0, 0, 4'h0, 8'h00, 32'h0);
        @(negedge clk0);
        chk("t5_csb_rd", sram_csb0, 0);
        chk("t5_web_rd", sram_web0, 1);
        next_cycle();
        @(negedge clk0);
        chk("t5_wr_rv", m1_resp_valid, 1);
        chk("t5_wr_rd_hold", m1_rdata, exp_rd1);
        next_cycle();
        @(negedge clk0);
        exp_rd1 = 32'h00000007;
        chk("t5_rd_rv", m1_resp_valid, 1);
        chk("t5_rd_data", m1_rdata, exp_rd1);
        chk("t5_rd0_quiet", m0_rdata, exp_rd0);
        next_cycle();
        check_idle("t5_end");

        // 6: reset one cycle after a read accept drops the read
        drive(0, 1, 0, 4'h0, 8'h05, 32'h0);
        @(negedge clk0);
        chk("t6_ready", m0_ready, 1);
        next_cycle();
        drive(0, 0, 0, 4'h0, 8'h00, 32'h0);
        rst = 1;
        @(negedge clk0);
        chk("t6_csb_pre", sram_csb0, 0);
        chk("t6_busy_pre", busy, 1);
        next_cycle();
        rst = 0;
        exp_rd0 = 32'h0;
        exp_rd1 = 32'h0;
        check_idle("t6_post0");
        check_idle("t6_post1");
        check_idle("t6_post2");
        single("t6_rd", 0, 0, 4'h0, 8'h05, 32'h0, 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
